// File: rtl/dp_lane_pattern_gen.sv
// DisplayPort main-link symbol source: per-lane idle/data/TPS1/TPS2 word generation
// followed by an optional inter-lane symbol skew stage, 4 symbols per lane per clock.
module dp_lane_pattern_gen #(
    parameter int LANES = 2,
    parameter int SKEW  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           ctl_mode,
    input  logic                 skew_en,
    input  logic [32*LANES-1:0]  datain,
    input  logic [4*LANES-1:0]   iskin,
    output logic [32*LANES-1:0]  txdata,
    output logic [4*LANES-1:0]   txisk,
    output logic [1:0]           mode_act,
    output logic                 tps2_wrap
);

    if (LANES < 1 || LANES > 4 || (LANES - 1) * SKEW > 12) begin : g_param_check
        $error("dp_lane_pattern_gen: LANES must be 1..4 and (LANES-1)*SKEW <= 12");
    end

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_DATA = 2'd1,
        MODE_TPS1 = 2'd2,
        MODE_TPS2 = 2'd3
    } mode_t;

    mode_t       mode_q, mode_d;
    logic [2:0]  idx_q, idx_d;
    logic        wrap_s1_q, wrap_s1_d;
    logic [31:0] pat_word;
    logic [3:0]  pat_isk;

    logic [31:0] s1_data_q [LANES];
    logic [3:0]  s1_isk_q  [LANES];
    logic [31:0] s1_data_d [LANES];
    logic [3:0]  s1_isk_d  [LANES];

    logic [31:0] h1_data_q [LANES];
    logic [31:0] h2_data_q [LANES];
    logic [31:0] h3_data_q [LANES];
    logic [3:0]  h1_isk_q  [LANES];
    logic [3:0]  h2_isk_q  [LANES];
    logic [3:0]  h3_isk_q  [LANES];

    logic [127:0] cat_data [LANES];
    logic [15:0]  cat_isk  [LANES];
    logic [3:0]   dly      [LANES];
    logic [31:0]  tx_data_d [LANES];
    logic [3:0]   tx_isk_d  [LANES];
    logic [31:0]  tx_data_q [LANES];
    logic [3:0]   tx_isk_q  [LANES];
    logic         wrap_s2_q;

    // Mode register and TPS2 index; a running TPS2 period only yields at idx4.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= MODE_IDLE;
            idx_q     <= 3'd0;
            wrap_s1_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            wrap_s1_q <= wrap_s1_d;
        end
    end

    always_comb begin
        mode_d    = mode_q;
        idx_d     = 3'd0;
        wrap_s1_d = 1'b0;
        pat_word  = 32'h4A4A4A4A;
        pat_isk   = 4'b0000;
        case (idx_q)
            3'd0:    begin pat_word = 32'hCBBCCBBC; pat_isk = 4'b0101; end
            3'd2:    begin pat_word = 32'hCBBC4A4A; pat_isk = 4'b0100; end
            3'd3:    begin pat_word = 32'h4A4ACBBC; pat_isk = 4'b0001; end
            default: begin pat_word = 32'h4A4A4A4A; pat_isk = 4'b0000; end
        endcase
        if (mode_q != MODE_TPS2 || idx_q == 3'd4) begin
            mode_d = mode_t'(ctl_mode);
        end
        if (mode_q == MODE_TPS2) begin
            idx_d     = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
            wrap_s1_d = (idx_q == 3'd4);
        end
        for (int n = 0; n < LANES; n++) begin
            s1_data_d[n] = 32'd0;
            s1_isk_d[n]  = 4'd0;
            case (mode_q)
                MODE_DATA: begin
                    s1_data_d[n] = datain[32*n +: 32];
                    s1_isk_d[n]  = iskin[4*n +: 4];
                end
                MODE_TPS1: s1_data_d[n] = 32'h4A4A4A4A;
                MODE_TPS2: begin
                    s1_data_d[n] = pat_word;
                    s1_isk_d[n]  = pat_isk;
                end
                default: ;
            endcase
        end
    end

    // Stream order oldest-first: h3 occupies bytes 0..3, the live stage-1 word bytes 12..15.
    always_comb begin
        for (int n = 0; n < LANES; n++) begin
            cat_data[n]  = {s1_data_q[n], h1_data_q[n], h2_data_q[n], h3_data_q[n]};
            cat_isk[n]   = {s1_isk_q[n], h1_isk_q[n], h2_isk_q[n], h3_isk_q[n]};
            dly[n]       = skew_en ? 4'(n * SKEW) : 4'd0;
            tx_data_d[n] = cat_data[n][8 * (12 - int'(dly[n])) +: 32];
            tx_isk_d[n]  = cat_isk[n][(12 - int'(dly[n])) +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_s2_q <= 1'b0;
            for (int n = 0; n < LANES; n++) begin
                s1_data_q[n] <= 32'd0;
                s1_isk_q[n]  <= 4'd0;
                h1_data_q[n] <= 32'd0;
                h2_data_q[n] <= 32'd0;
                h3_data_q[n] <= 32'd0;
                h1_isk_q[n]  <= 4'd0;
                h2_isk_q[n]  <= 4'd0;
                h3_isk_q[n]  <= 4'd0;
                tx_data_q[n] <= 32'd0;
                tx_isk_q[n]  <= 4'd0;
            end
        end else begin
            wrap_s2_q <= wrap_s1_q;
            for (int n = 0; n < LANES; n++) begin
                s1_data_q[n] <= s1_data_d[n];
                s1_isk_q[n]  <= s1_isk_d[n];
                h1_data_q[n] <= s1_data_q[n];
                h2_data_q[n] <= h1_data_q[n];
                h3_data_q[n] <= h2_data_q[n];
                h1_isk_q[n]  <= s1_isk_q[n];
                h2_isk_q[n]  <= h1_isk_q[n];
                h3_isk_q[n]  <= h2_isk_q[n];
                tx_data_q[n] <= tx_data_d[n];
                tx_isk_q[n]  <= tx_isk_d[n];
            end
        end
    end

    always_comb begin
        txdata = '0;
        txisk  = '0;
        for (int n = 0; n < LANES; n++) begin
            txdata[32*n +: 32] = tx_data_q[n];
            txisk[4*n +: 4]    = tx_isk_q[n];
        end
    end

    assign mode_act  = mode_q;
    assign tps2_wrap = wrap_s2_q;

endmodule
